// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state type, default timing and helpers for bit_serializer
package bit_serializer_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_RDY = 3'd1,
      S_SETUP    = 3'd2,
      S_STROBE   = 3'd3,
      S_GAP      = 3'd4
   } ser_state_t;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_SETUP_CYCLES = 10;
   localparam int DEF_HOLD_CYCLES  = 10;
   localparam int DEF_GAP_CYCLES   = 10;

   // Largest of three phase lengths; sizes the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-flop rising-edge detector for a same-clock level
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig_in,
   output logic rise_out
);

   logic prev_q;
   logic prev_d;

   // Next value of the delayed copy is simply the current level.
   always_comb begin
      prev_d = sig_in;
   end

   // Delayed copy of the level; cleared so a level already high after reset reads as an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - byte-to-serial transmitter with setup/strobe/gap bit timing (option: BIT_SERIALIZER_MSB_FIRST_EN)
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic                  status_in,
   output logic                  data_out,
   output logic                  write_out,
   output logic                  busy_out,
   output logic                  done_out
);

   localparam int PH_MAX = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [PH_W-1:0]  SETUP_LOAD = PH_W'(SETUP_CYCLES - 1);
   localparam logic [PH_W-1:0]  HOLD_LOAD  = PH_W'(HOLD_CYCLES - 1);
   localparam logic [PH_W-1:0]  GAP_LOAD   = PH_W'(GAP_CYCLES - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

   ser_state_t            state_q,     state_d;
   logic [DATA_WIDTH-1:0] shift_q,     shift_d;
   logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [PH_W-1:0]       phase_q,     phase_d;
   logic                  armed_q,     armed_d;
   logic                  data_out_q,  data_out_d;
   logic                  write_out_q, write_out_d;
   logic                  done_q,      done_d;

   logic                  status_rise;
   logic                  wait_exit;
   logic [DATA_WIDTH-1:0] shift_adv;
   logic                  head_now;
   logic                  head_adv;

   rise_detect u_rise_detect (
      .clock    (clock),
      .reset    (reset),
      .sig_in   (status_in),
      .rise_out (status_rise)
   );

   // Bit order selection: the shift direction and the tapped end of the register.
   always_comb begin
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      shift_adv = {shift_q[DATA_WIDTH-2:0], 1'b0};
      head_now  = shift_q[DATA_WIDTH-1];
      head_adv  = shift_adv[DATA_WIDTH-1];
`else
      shift_adv = {1'b0, shift_q[DATA_WIDTH-1:1]};
      head_now  = shift_q[0];
      head_adv  = shift_adv[0];
`endif
   end

   // Next-state, counters and registered-output values for the transmit sequence.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      phase_d     = phase_q;
      data_out_d  = data_out_q;
      write_out_d = 1'b0;
      done_d      = 1'b0;
      wait_exit   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               shift_d   = data_in;
               bit_cnt_d = '0;
               state_d   = S_WAIT_RDY;
            end
         end

         S_WAIT_RDY: begin
            if (armed_q) begin
               wait_exit  = 1'b1;
               phase_d    = SETUP_LOAD;
               data_out_d = head_now;
               state_d    = S_SETUP;
            end
         end

         S_SETUP: begin
            if (phase_q == '0) begin
               phase_d     = HOLD_LOAD;
               write_out_d = 1'b1;
               state_d     = S_STROBE;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end

         S_STROBE: begin
            if (phase_q == '0) begin
               phase_d = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               phase_d     = phase_q - 1'b1;
               write_out_d = 1'b1;
            end
         end

         S_GAP: begin
            if (phase_q == '0) begin
               if (bit_cnt_q < LAST_BIT) begin
                  shift_d    = shift_adv;
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  phase_d    = SETUP_LOAD;
                  data_out_d = head_adv;
                  state_d    = S_SETUP;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A fresh edge always arms, even on the cycle a previous arm is consumed.
      armed_d = status_rise | (armed_q & ~wait_exit);
   end

   // State, datapath and output registers; reset abandons any partial word at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         phase_q     <= '0;
         armed_q     <= 1'b0;
         data_out_q  <= 1'b0;
         write_out_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         phase_q     <= phase_d;
         armed_q     <= armed_d;
         data_out_q  <= data_out_d;
         write_out_q <= write_out_d;
         done_q      <= done_d;
      end
   end

   assign ready_out = (state_q == S_IDLE);
   assign busy_out  = (state_q != S_IDLE);
   assign data_out  = data_out_q;
   assign write_out = write_out_q;
   assign done_out  = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer
module tb_bit_serializer;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       status_in;
   logic       data_out;
   logic       write_out;
   logic       busy_out;
   logic       done_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic       wr_prev = 1'b0;
   int         hi_len = 0;
   logic [7:0] rx_bits = '0;
   int         rx_n = 0;
   int         strobe_total = 0;
   int         first_rise_cyc = 0;

   bit_serializer dut (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .status_in (status_in),
      .data_out  (data_out),
      .write_out (write_out),
      .busy_out  (busy_out),
      .done_out  (done_out)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Strobe monitor: records the bit on each rising strobe and checks every strobe width.
   always @(negedge clock) begin
      if (reset) begin
         hi_len  = 0;
         wr_prev = 1'b0;
      end else begin
         if (write_out && !wr_prev) begin
            if (rx_n < 8) rx_bits[rx_n] = data_out;
            if (rx_n == 0) first_rise_cyc = cyc;
            rx_n++;
            strobe_total++;
            hi_len = 1;
         end else if (write_out) begin
            hi_len++;
         end else if (wr_prev) begin
            check("strobe_hold", hi_len, 10);
         end
         wr_prev = write_out;
      end
   end

   typedef struct {
      logic [7:0] data;
      bit         early;
      logic [7:0] exp_seq;
      int         exp_done;
      int         exp_rise;
   } vec_t;

   vec_t vecs[6];

   task automatic wait_done(output int dc);
      dc = -1;
      for (int i = 0; i < 600; i++) begin
         if (done_out === 1'b1) begin
            dc = cyc;
            break;
         end
         @(negedge clock);
      end
      if (dc < 0) check("done_timeout", 0, 1);
   endtask

   task automatic send(input logic [7:0] d, output int t0);
      check("ready_before_send", ready_out, 1);
      data_in  = d;
      valid_in = 1'b1;
      @(posedge clock);
      @(negedge clock);
      valid_in = 1'b0;
      t0 = cyc;
      check("busy_after_send", busy_out, 1);
   endtask

   task automatic run_word(input vec_t v);
      int t0;
      int dc;
      status_in = 1'b0;
      repeat (2) @(negedge clock);
      if (v.early) begin
         status_in = 1'b1;
         repeat (2) @(negedge clock);
      end
      rx_n = 0;
      send(v.data, t0);
      if (!v.early) begin
         repeat (10) @(negedge clock);
         status_in = 1'b1;
      end
      wait_done(dc);
      check("done_latency", dc - t0, v.exp_done);
      check("first_strobe", first_rise_cyc - t0, v.exp_rise);
      check("strobe_count", rx_n, 8);
      check("bit_sequence", rx_bits, v.exp_seq);
      check("ready_with_done", ready_out, 1);
      @(negedge clock);
      check("done_one_cycle", done_out, 0);
   endtask

   initial begin
      int s0;
      int t0;
      int dc;

      // exp_seq bit i is the i-th bit on the wire (LSB first).
      vecs[0] = '{8'h99, 1'b0, 8'b1001_1001, 252, 22};
      vecs[1] = '{8'h00, 1'b0, 8'b0000_0000, 252, 22};
      vecs[2] = '{8'h01, 1'b0, 8'b0000_0001, 252, 22};
      vecs[3] = '{8'h02, 1'b0, 8'b0000_0010, 252, 22};
      vecs[4] = '{8'h03, 1'b0, 8'b0000_0011, 252, 22};
      vecs[5] = '{8'hC3, 1'b1, 8'b1100_0011, 241, 11};

      reset     = 1'b1;
      data_in   = '0;
      valid_in  = 1'b0;
      status_in = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_ready", ready_out, 1);
         check("rst_busy", busy_out, 0);
         check("rst_write", write_out, 0);
         check("rst_data", data_out, 0);
      end
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("idle_ready", ready_out, 1);
      check("idle_busy", busy_out, 0);

      s0 = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) s0 = strobe_total;
         run_word(vecs[i]);
         if (i == 4) check("four_word_strobes", strobe_total - s0, 32);
      end

      // Status already high: the word must wait for a new low-to-high edge.
      status_in = 1'b1;
      repeat (3) @(negedge clock);
      rx_n = 0;
      send(8'h5A, t0);
      repeat (20) @(negedge clock);
      check("held_status_no_strobe", rx_n, 0);
      check("held_status_busy", busy_out, 1);
      status_in = 1'b0;
      @(negedge clock);
      status_in = 1'b1;
      wait_done(dc);
      check("held_status_bits", rx_bits, 8'h5A);

      // valid_in stays high with a different byte while busy.
      status_in = 1'b0;
      repeat (2) @(negedge clock);
      rx_n     = 0;
      data_in  = 8'h0F;
      valid_in = 1'b1;
      @(posedge clock);
      @(negedge clock);
      data_in = 8'hF0;
      repeat (10) @(negedge clock);
      status_in = 1'b1;
      wait_done(dc);
      valid_in = 1'b0;
      check("busy_bits", rx_bits, 8'h0F);
      check("busy_strobes", rx_n, 8);
      repeat (3) @(negedge clock);
      check("busy_not_accepted", busy_out, 0);

      // Reset during bit 4's strobe, then a clean word.
      status_in = 1'b0;
      repeat (2) @(negedge clock);
      rx_n = 0;
      send(8'h3C, t0);
      repeat (2) @(negedge clock);
      status_in = 1'b1;
      for (int i = 0; i < 400 && rx_n < 5; i++) @(negedge clock);
      check("mid_strobe_reached", rx_n, 5);
      check("mid_write_high", write_out, 1);
      check("mid_data_bit4", data_out, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_write", write_out, 0);
      check("mid_rst_data", data_out, 0);
      check("mid_rst_ready", ready_out, 1);
      check("mid_rst_busy", busy_out, 0);
      status_in = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("post_rst_idle", busy_out, 0);
      run_word('{8'hA5, 1'b0, 8'b1010_0101, 252, 22});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
